// File: rtl/uart_word_bridge.sv
// 32-bit word <-> byte-wide UART transceiver bridge.
// TX serializes words MSB-first with a word-count trailer per frame; RX assembles 4 bytes per word.
module uart_word_bridge #(
    parameter int unsigned RX_TIMEOUT = 65536
) (
    input  logic        sys_clk,
    input  logic        sys_nrst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        rx_overrun,
    input  logic        clr_status
);

    localparam int unsigned IDLE_W = $clog2(RX_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(RX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TRAIL = 2'd2
    } tx_state_t;

    tx_state_t         r_state;
    logic              r_in_ready;
    logic [31:0]       r_shift;
    logic [31:0]       r_frame_cnt;
    logic [1:0]        r_idx;
    logic              r_last;

    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_partial;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic              r_overrun;

    logic              w_tx_fire;
    logic              w_rx_done;
    logic              w_drop;

    // A byte goes to the FIFO in any cycle the FSM holds one and the FIFO has room.
    assign w_tx_fire  = (r_state != ST_IDLE) && !tx_full;
    assign tx_valid   = w_tx_fire;
    assign tx_data    = {24'h00_0000, r_shift[31:24]};
    assign in_ready   = r_in_ready;

    assign w_rx_done  = rx_valid && (r_byte_cnt == 2'd3);
    assign w_drop     = w_rx_done && r_out_valid && !out_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign rx_overrun = r_overrun;

    // TX framing FSM: word bytes, then the frame word count after a last word.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_shift     <= 32'h0000_0000;
            r_frame_cnt <= 32'h0000_0000;
            r_idx       <= 2'd0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_shift     <= in_data;
                        r_last      <= in_last;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                        r_idx       <= 2'd0;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tx_fire) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            if (r_last) begin
                                r_shift <= r_frame_cnt;
                                r_state <= ST_TRAIL;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (w_tx_fire) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_frame_cnt <= 32'h0000_0000;
                            r_in_ready  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // RX assembly with inter-byte timeout; a stale partial word is silently dropped.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_byte_cnt  <= 2'd0;
            r_partial   <= 24'h00_0000;
            r_idle_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_overrun   <= 1'b0;
        end else begin
            if (rx_valid) begin
                r_idle_cnt <= '0;
                r_partial  <= {r_partial[15:0], rx_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else begin
                if (r_idle_cnt != IDLE_MAX) begin
                    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                end
                if ((r_byte_cnt != 2'd0) && (r_idle_cnt == IDLE_MAX)) begin
                    r_byte_cnt <= 2'd0;
                end
            end

            if (w_rx_done) begin
                if (!w_drop) begin
                    r_out_data  <= {r_partial, rx_data};
                    r_out_valid <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Setting wins over a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_word_bridge.md
# uart_word_bridge

Converts between 32-bit word streams and the byte-wide UART transceiver used for IP validation. TX path: accepts words from the encoder output, serializes them MSB-first into the transceiver TX FIFO under `tx_full` backpressure, and appends a 4-byte word-count trailer after each `in_last` word. RX path: assembles 4 received bytes into one 32-bit word for the block under test. Includes an inter-byte timeout and an overrun flag.

## Interface
- `RX_TIMEOUT`, default 65536: sys_clk cycles without `rx_valid` after which a partial RX word is discarded (≥2).
- `sys_clk` in 1: clock.
- `sys_nrst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream word valid.
- `in_data` in 32: upstream word.
- `in_last` in 1: word is last of frame; sampled with `in_data`.
- `in_ready` out 1: bridge accepts a word this cycle.
- `tx_valid` out 1: write one byte to the transceiver TX FIFO.
- `tx_data` out 32: byte in [7:0]; [31:8] always 0.
- `tx_full` in 1: transceiver TX FIFO full.
- `rx_valid` in 1: one received byte, single-cycle pulse.
- `rx_data` in 8: received byte.
- `out_valid` out 1: assembled RX word available.
- `out_data` out 32: assembled RX word; first received byte in [31:24].
- `out_ready` in 1: downstream consumes the word.
- `rx_overrun` out 1: sticky; a completed word was dropped.
- `clr_status` in 1: synchronous clear of `rx_overrun`.

## Operation
- TX FSM states: IDLE, DATA, TRAIL.
  - IDLE: `in_ready`=1. If `in_valid`, it loads the shift register from `in_data`, latches `in_last`, increments `frame_cnt` (32-bit, wraps), sets byte index 0, and goes to DATA.
  - DATA: `tx_valid` = ~`tx_full` (combinational). `tx_data[7:0]` is the shift register [31:24]. Each emitted byte shifts left 8 and increments the index.
  - After byte 3 is emitted, the FSM goes to TRAIL if last is latched, else to IDLE.
  - TRAIL: the shift register is loaded with `frame_cnt` on entry and emits 4 bytes MSB-first under the same rule. `frame_cnt` is cleared when the 4th byte is emitted, then the FSM returns to IDLE.
  - Trailer value counts the words of the frame including the last word. A frame of 1 word sends trailer 00 00 00 01.
  - `in_ready` is 0 in DATA and TRAIL.
- RX assembler: byte counter 0..3 and a 24-bit partial register.
  - Each `rx_valid` stores a byte and increments the counter.
  - On the 4th byte, the word {partial, rx_data} is formed and the counter returns to 0.
  - Completion while `out_valid`=1 and `out_ready`=0: the new word is dropped, `out_data` is unchanged, and `rx_overrun` is set.
  - Completion while `out_valid`=0, or while `out_valid`=1 and `out_ready`=1: `out_data` loads the new word and `out_valid`=1.
  - `out_valid`&`out_ready` with no completion the same cycle clears `out_valid`.
- RX timeout: the idle counter resets on every `rx_valid` and counts otherwise. When the byte counter ≠0 and the idle counter reaches `RX_TIMEOUT`-1, the byte counter clears. The partial word is discarded and no flag is raised.
- `rx_overrun`: the set condition has priority over `clr_status` in the same cycle.

## Timing
- Reset values: `in_ready`=0 in the cycle reset is asserted, then 1 (IDLE). All other outputs are 0: `tx_valid`, `tx_data`, `out_valid`, `out_data`, `rx_overrun`. FSM in IDLE, `frame_cnt`=0, RX counters=0.
- Reset mid-frame discards all TX and RX state. No partial trailer is sent after reset.
- TX latency: the first byte can be presented on `tx_valid` the cycle after acceptance.
- With `tx_full`=0 throughout:
  - A non-last word takes 5 cycles (1 accept + 4 bytes).
  - A last word takes 9 cycles.
- `tx_full`=1 stalls the byte with no loss and no duplication. At most one byte is written per cycle.
- RX latency: `out_valid` rises the cycle after the 4th `rx_valid`.
- Back-to-back `rx_valid` on consecutive cycles is supported.

## Test plan
- Single-word frame: send 0x11223344 with `in_last`=1 and `tx_full`=0. Required bytes: 11 22 33 44 00 00 00 01, with `in_ready` low for 8 cycles.
- Three-word frame with `tx_full` toggling every other cycle. Required: byte order and count are preserved and the trailer is 00 00 00 03. The next frame's trailer restarts at 1.
- RX bytes DE AD BE EF with `out_ready`=1. Required: `out_data`=0xDEADBEEF and a one-cycle `out_valid`.
- Two RX words with `out_ready`=0. Required: `out_data` stays at the first word and `rx_overrun`=1. Asserting `clr_status` clears `rx_overrun`.
- With `RX_TIMEOUT`=16: send 2 bytes, stay idle 16 cycles, then send AA BB CC DD. Required: `out_data`=0xAABBCCDD.
- Assert reset during TRAIL, then send a 1-word frame. Required: no leftover bytes, and the trailer is 00 00 00 01.
